yuv422_lane_packer: RTL
=======================

# yuv422_lane_packer

Downstream stage of the Sony block-camera front end. Consumes the byte stream (8-bit YUV422, doubled pixel clock) with the FV/LV framing recovered from the embedded sync codes. Packs pixel bytes into 32-bit words for the 4-lane CSI-2 packetizer and emits frame/line start/end strobes, the per-line byte count and a line error flag. An optional per-line payload CRC-16 can be compiled in.

## Interface
- BYTES_PER_LINE, 3840, expected pixel bytes per line (1920 px YUV422)
- clock_in  input  1  doubled pixel clock, same domain as the front end output
- reset  input  1  synchronous, active-high
- data_in  input  8  pixel byte from the front end
- FV  input  1  frame valid
- LV  input  1  line valid; `data_in` is a pixel byte in every cycle with LV=1
- word_out  output  32  packed lane word; first byte in [7:0], fourth in [31:24]
- word_valid  output  1  `word_out` valid, one-cycle strobe per word
- fs_pulse  output  1  frame start strobe
- fe_pulse  output  1  frame end strobe
- ls_pulse  output  1  line start strobe
- le_pulse  output  1  line end strobe
- word_count  output  16  byte count of the line just closed, valid with `le_pulse`
- line_err  output  1  sticky; cleared at `fs_pulse`
- crc_out  output  16  payload CRC of the closed line, valid with `le_pulse`

## Operation
- Inputs are registered once (`FV_q`, `LV_q`, `data_q`). Edges are detected against the previous registered values.
- FSM states:
  - IDLE: wait for FV rise, then emit `fs_pulse` and go to FRAME.
  - FRAME: wait for LV rise, then emit `ls_pulse` and go to LINE.
  - LINE: accumulate bytes. On LV fall or FV fall, go to CLOSE.
  - CLOSE: one cycle. Flush any partial word, emit `le_pulse`, then go to FRAME, or go to IDLE with `fe_pulse` if FV is low.
- FV falls in FRAME: emit `fe_pulse` and go to IDLE.
- Byte lane index is 2 bits and wraps modulo 4. The 4th byte completes the word.
- Partial final word: unused upper bytes are 0x00. It is emitted in the CLOSE cycle with `word_valid`=1.
- Byte counter is 16 bits, saturating at 0xFFFF. `word_count` is the saturated value and excludes pad bytes.
- `line_err` is set in CLOSE when the byte count is not equal to BYTES_PER_LINE, including on saturation and when FV falls mid-line.
- LV high while FV low (IDLE): bytes are ignored. No strobes, no words, no error.
- FV and LV rising in the same sample: `fs_pulse` is emitted first, and `ls_pulse` follows one cycle later. The first pixel bytes are still captured (the FRAME state takes LV=1 directly).
- Reset mid-line: all outputs are 0 on the next cycle and the FSM goes to IDLE. No `le_pulse` or `fe_pulse` is emitted for the aborted frame.
- Reset values: `word_out`=0, `word_valid`=0, all strobes=0, `word_count`=0, `line_err`=0, `crc_out`=0.

## Timing
- Byte sampled at `data_in` in cycle t is in `data_q` at t+1.
- A word completed by the byte present at cycle t has `word_valid`=1 at t+2.
- LV first-high at cycle t: `ls_pulse` at t+2.
- LV first-low at cycle t: CLOSE at t+2, so `le_pulse`, `word_count`, `crc_out` and any pad word all appear at t+2.
- `fe_pulse` comes one cycle after `le_pulse` when the line was closed by FV fall. Otherwise it comes at FV-low-detect +2.
- All strobes are single-cycle. At most one `word_valid` per cycle. There is no back-pressure: the consumer must accept every word.

## Configuration
- `LANE_PACKER_CRC_EN` defined: `crc_out` is the CSI-2 payload CRC-16.
  - Polynomial x^16+x^12+x^5+1, bit-reflected (LSB-first).
  - Initial value 0xFFFF, reset to 0xFFFF at every `ls_pulse`.
  - Covers pixel bytes only; pad bytes are excluded.
- `LANE_PACKER_CRC_EN` undefined: no CRC logic is built and `crc_out` is tied to 0.

## Structure
- Shared package `sony_csi_pkg`: FSM state enum (IDLE, FRAME, LINE, CLOSE), default BYTES_PER_LINE, CRC polynomial/init constants, lane count (4).
- Sub-module `csi2_crc16_byte`: combinational one-byte reflected CRC update (crc_in, byte → crc_out), instantiated only under the macro.

## Test plan
- Frame with 2 lines of 3840 incrementing bytes (00,01,…,FF,00,…).
  - 960 words per line; first word 0x03020100.
  - `word_count`=3840; `line_err`=0.
  - One `fs_pulse` / `fe_pulse`; two `ls_pulse` / `le_pulse` pairs.
- Line of 3842 bytes, last two bytes AA,BB.
  - Final word 0x0000BBAA emitted with `le_pulse`.
  - `word_count`=3842; `line_err`=1 until the next `fs_pulse`.
- CRC build, line of the 24 bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → `crc_out`=0x00F0.
- FV falls mid-line after 100 bytes → pad word, `le_pulse` with `word_count`=100, `line_err`=1, `fe_pulse` next cycle.
- LV pulses of 16 bytes with FV low → no `word_valid`, no strobes, `line_err` stays 0.
- `reset` asserted at byte 500 of a line → all outputs 0 next cycle. No `le_pulse`. The next frame starts cleanly with `fs_pulse`.

Source files
------------

// File: rtl/sony_csi_pkg.sv
// Shared definitions for the Sony block-camera CSI-2 front end: packer FSM states,
// default line length, lane count and payload CRC-16 constants.
package sony_csi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FRAME,
      LINE,
      CLOSE
   } state_t;

   localparam int          DEFAULT_BYTES_PER_LINE = 3840;
   localparam int          LANES                  = 4;
   // x^16+x^12+x^5+1 in bit-reflected (LSB-first) form
   localparam logic [15:0] CRC_POLY               = 16'h8408;
   localparam logic [15:0] CRC_INIT               = 16'hFFFF;

endpackage

// File: rtl/csi2_crc16_byte.sv
// Combinational one-byte update of the reflected CSI-2 payload CRC-16.
module csi2_crc16_byte
   import sony_csi_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_byte,
   output logic [15:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {8'h00, data_byte};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/yuv422_lane_packer.sv
// Packs the FV/LV-framed YUV422 byte stream into 32-bit lane words with frame/line strobes.
// Define LANE_PACKER_CRC_EN to build the per-line payload CRC-16 on crc_out.
module yuv422_lane_packer
   import sony_csi_pkg::*;
#(
   parameter int BYTES_PER_LINE = DEFAULT_BYTES_PER_LINE
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        FV,
   input  logic        LV,
   output logic [31:0] word_out,
   output logic        word_valid,
   output logic        fs_pulse,
   output logic        fe_pulse,
   output logic        ls_pulse,
   output logic        le_pulse,
   output logic [15:0] word_count,
   output logic        line_err,
   output logic [15:0] crc_out
);

   localparam logic [15:0] LINE_BYTES = 16'(BYTES_PER_LINE);
   localparam logic [1:0]  LAST_LANE  = 2'(LANES - 1);

   state_t      state, state_next;
   logic        FV_q, LV_q, FV_qq, LV_qq;
   logic [7:0]  data_q;
   logic [1:0]  lane;
   logic [23:0] acc;
   logic [15:0] byte_cnt;
   logic        capture, close, clear;
   logic        fs_next, fe_next, ls_next;

   // NOTE: every output of this block is defaulted first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      close      = 1'b0;
      clear      = 1'b0;
      fs_next    = 1'b0;
      fe_next    = 1'b0;
      ls_next    = 1'b0;
      unique case (state)
         IDLE: begin
            if (FV_q && !FV_qq) begin
               fs_next    = 1'b1;
               // FV and LV rising together: keep the first byte, FRAME picks up the rest
               capture    = LV_q && !LV_qq;
               state_next = FRAME;
            end
         end
         FRAME: begin
            if (!FV_q) begin
               fe_next    = 1'b1;
               clear      = 1'b1;
               state_next = IDLE;
            end else if (LV_q) begin
               ls_next    = 1'b1;
               capture    = 1'b1;
               state_next = LINE;
            end
         end
         LINE: begin
            if (!FV_q || !LV_q) begin
               close      = 1'b1;
               state_next = CLOSE;
            end else begin
               capture    = 1'b1;
            end
         end
         CLOSE: begin
            if (!FV_q) begin
               fe_next    = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = FRAME;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state      <= IDLE;
         FV_q       <= 1'b0;
         LV_q       <= 1'b0;
         FV_qq      <= 1'b0;
         LV_qq      <= 1'b0;
         data_q     <= '0;
         lane       <= '0;
         acc        <= '0;
         byte_cnt   <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         fs_pulse   <= 1'b0;
         fe_pulse   <= 1'b0;
         ls_pulse   <= 1'b0;
         le_pulse   <= 1'b0;
         word_count <= '0;
         line_err   <= 1'b0;
      end else begin
         FV_q       <= FV;
         LV_q       <= LV;
         FV_qq      <= FV_q;
         LV_qq      <= LV_q;
         data_q     <= data_in;
         state      <= state_next;
         fs_pulse   <= fs_next;
         fe_pulse   <= fe_next;
         ls_pulse   <= ls_next;
         le_pulse   <= close;
         word_valid <= 1'b0;

         if (fs_next) line_err <= 1'b0;

         if (capture) begin
            byte_cnt <= (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
            lane     <= lane + 2'd1;
            if (lane == LAST_LANE) begin
               word_out   <= {data_q, acc};
               word_valid <= 1'b1;
               acc        <= '0;
            end else begin
               acc[{lane, 3'b000} +: 8] <= data_q;
            end
         end

         // Unfilled upper bytes of acc are still zero, which is exactly the pad.
         if (close) begin
            if (lane != 2'd0) begin
               word_out   <= {8'h00, acc};
               word_valid <= 1'b1;
            end
            word_count <= byte_cnt;
            if (byte_cnt != LINE_BYTES) line_err <= 1'b1;
         end

         if (close || clear) begin
            lane     <= '0;
            acc      <= '0;
            byte_cnt <= '0;
         end
      end
   end

`ifdef LANE_PACKER_CRC_EN
   logic [15:0] crc, crc_upd;

   csi2_crc16_byte u_crc (
      .crc_in    (crc),
      .data_byte (data_q),
      .crc_out   (crc_upd)
   );

   // The running CRC sits at its initial value outside a line, so it is fresh at every ls_pulse.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         crc     <= CRC_INIT;
         crc_out <= '0;
      end else begin
         if (close || clear) crc <= CRC_INIT;
         else if (capture)   crc <= crc_upd;
         if (close) crc_out <= crc;
      end
   end
`else
   assign crc_out = '0;
`endif

endmodule
